// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared register-file widths and writeback arbiter state type
package my_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ARB_NORMAL,
        ARB_STARVE
    } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy vector for registers awaiting long-latency results
module rf_scoreboard
    import my_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic [31:0]           busy_o
);

    logic [31:0] busy_q, busy_d;

    // Set is applied after clear so a re-issue to the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy1  = busy_q[q_rs1];
    assign busy2  = busy_q[q_rs2];
    assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges pipeline and long-latency writebacks onto one register-file write port
module rf_wb_arbiter
    import my_pkg::*;
#(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  stall_pipe,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic                  err_waw
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pipe_need, starve, lu_acc, pipe_commit, lu_commit;
    logic [31:0]           busy_vec;
    logic                  wr_en_q, err_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign pipe_need   = pipe_valid && (pipe_rd != '0);
    assign starve      = (state_q == ARB_STARVE);
    assign lu_ready    = starve || !pipe_need;
    assign stall_pipe  = starve && pipe_need;
    assign lu_acc      = lu_valid && lu_ready;
    assign pipe_commit = pipe_need && !stall_pipe;
    assign lu_commit   = !pipe_commit && lu_acc && (lu_rd != '0);

    // STARVE is entered as the wait count reaches the limit, so the forced slot
    // lands on the cycle right after STARVE_MAX refused cycles.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = ARB_NORMAL;
        if (lu_acc)
            cnt_d = '0;
        else if (lu_valid && cnt_q != STARVE_LIM)
            cnt_d = cnt_q + 4'd1;
        if (state_q == ARB_NORMAL && lu_valid && !lu_acc && cnt_d == STARVE_LIM)
            state_d = ARB_STARVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= pipe_commit || lu_commit;
            if (pipe_commit) begin
                addr_q <= pipe_rd;
                data_q <= pipe_data;
            end else if (lu_commit) begin
                addr_q <= lu_rd;
                data_q <= lu_data;
            end
            if (pipe_commit && busy_vec[pipe_rd]) err_q <= 1'b1;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (iss_valid),
        .set_rd (iss_rd),
        .clr_en (lu_acc),
        .clr_rd (lu_rd),
        .q_rs1  (q_rs1),
        .q_rs2  (q_rs2),
        .busy1  (busy1),
        .busy2  (busy2),
        .busy_o (busy_vec)
    );

    assign wr_en   = wr_en_q;
    assign addr_wr = addr_q;
    assign data_wr = data_q;
    assign err_waw = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed bench for rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
    import my_pkg::*;

    localparam int DW   = DATA_WIDTH;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pipe_valid, lu_valid, iss_valid;
    logic [4:0]    pipe_rd, lu_rd, iss_rd, q_rs1, q_rs2;
    logic [DW-1:0] pipe_data, lu_data;
    logic          stall_pipe, lu_ready, busy1, busy2, wr_en, err_waw;
    logic [4:0]    addr_wr;
    logic [DW-1:0] data_wr;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .stall_pipe(stall_pipe),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .busy1(busy1), .busy2(busy2),
        .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: which registers await an LU result, how long the LU has waited, last write.
    logic [31:0]   m_busy;
    int            m_wait;
    logic          m_wr, m_err, m_acc;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic          s_ready, s_stall, s_b1;

    int            low;
    logic          lu_pend;
    logic [4:0]    p_rd, l_rd;
    logic [DW-1:0] p_d, l_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_wait = 0; m_wr = 1'b0; m_err = 1'b0; m_acc = 1'b0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [DW-1:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] q1, input logic [4:0] q2);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        iss_valid = iv; iss_rd = ird; q_rs1 = q1; q_rs2 = q2;
    endtask

    // Called just after a rising edge with inputs applied; checks, advances the model, returns after the next edge.
    task automatic step();
        logic pneed, forced, e_ready, e_stall, pcommit;
        pneed   = pipe_valid && (pipe_rd != 5'd0);
        forced  = lu_valid && (m_wait >= SMAX);
        e_ready = forced || !pneed;
        e_stall = forced && pneed;
        #1;
        s_ready = lu_ready; s_stall = stall_pipe; s_b1 = busy1;
        check("lu_ready",   lu_ready,   e_ready);
        check("stall_pipe", stall_pipe, e_stall);
        check("busy1",      busy1,      m_busy[q_rs1]);
        check("busy2",      busy2,      m_busy[q_rs2]);
        check("wr_en",      wr_en,      m_wr);
        check("addr_wr",    addr_wr,    m_addr);
        check("data_wr",    data_wr,    m_data);
        check("err_waw",    err_waw,    m_err);
        m_acc   = lu_valid && e_ready;
        pcommit = pneed && !e_stall;
        if (pcommit && m_busy[pipe_rd]) m_err = 1'b1;
        if (pcommit) begin
            m_wr = 1'b1; m_addr = pipe_rd; m_data = pipe_data;
        end else if (m_acc && lu_rd != 5'd0) begin
            m_wr = 1'b1; m_addr = lu_rd; m_data = lu_data;
        end else begin
            m_wr = 1'b0;
        end
        if (m_acc) m_busy[lu_rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (m_acc) m_wait = 0;
        else if (lu_valid && m_wait < SMAX) m_wait++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_lu_ready", lu_ready, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        check("rst_busy2", busy2, 1'b0);
        check("rst_err", err_waw, 1'b0);
        check("rst_stall", stall_pipe, 1'b0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pipeline write, then the same write aimed at x0.
        drive(1, 5, 'h1234, 0, 0, 0, 0, 0, 0, 0); step();
        check("pipe_wr_en", wr_en, 1'b1);
        check("pipe_addr", addr_wr, 5'd5);
        check("pipe_data", data_wr, 'h1234);
        drive(1, 0, 'h5555, 0, 0, 0, 0, 0, 0, 0); step();
        check("x0_wr_en", wr_en, 1'b0);

        // Issue to x7, then LU result for x7 with the pipeline idle.
        drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0); step();
        drive(0, 0, 0, 1, 7, 'hCAFE, 0, 0, 7, 0); step();
        check("lu7_busy_before", s_b1, 1'b1);
        check("lu7_accept", s_ready, 1'b1);
        check("lu7_busy_after", busy1, 1'b0);
        check("lu7_wr_en", wr_en, 1'b1);
        check("lu7_addr", addr_wr, 5'd7);
        check("lu7_data", data_wr, 'hCAFE);

        // Back-to-back pipeline writes against a held LU result.
        low = 0; s_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!s_stall) begin
                p_rd = 5'(i + 10); p_d = DW'(32'h100 + i);
            end
            drive(1, p_rd, p_d, 1, 3, 'hBEEF, 0, 0, 0, 0); step();
            if (s_ready) break;
            low++;
        end
        check("starve_low_cycles", low, SMAX);
        check("starve_stall", s_stall, 1'b1);
        check("starve_lu_addr", addr_wr, 5'd3);
        check("starve_lu_data", data_wr, 'hBEEF);
        drive(1, p_rd, p_d, 0, 0, 0, 0, 0, 0, 0); step();
        check("starve_pipe_resume_addr", addr_wr, p_rd);
        check("starve_pipe_resume_data", data_wr, p_d);

        // Re-issue to x9 on the cycle its result retires, then a pipeline write to busy x9.
        drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0); step();
        drive(0, 0, 0, 1, 9, 'h1, 1, 9, 9, 0); step();
        check("waw_lu_accept", s_ready, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0); step();
        check("set_wins_busy9", s_b1, 1'b1);
        drive(1, 9, 'h99, 0, 0, 0, 0, 0, 0, 9); step();
        check("waw_err_set", err_waw, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        end
        check("waw_err_sticky", err_waw, 1'b1);

        // Asynchronous reset with a write in flight, busy bits set and an LU result waiting.
        drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 9); step();
        drive(1, 4, 'h44, 1, 6, 'h66, 0, 0, 12, 9); step();
        #2;
        rst_n = 1'b0; pipe_valid = 1'b0; lu_valid = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 1'b0);
        check("arst_addr", addr_wr, 5'd0);
        check("arst_data", data_wr, 0);
        check("arst_busy1", busy1, 1'b0);
        check("arst_busy2", busy2, 1'b0);
        check("arst_err", err_waw, 1'b0);
        check("arst_lu_ready", lu_ready, 1'b1);
        check("arst_stall", stall_pipe, 1'b0);
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic; LU holds its offer until accepted, pipeline holds while stalled.
        lu_pend = 1'b0; s_stall = 1'b0; l_rd = 0; l_d = 0; p_rd = 0; p_d = 0;
        pipe_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!lu_pend && $urandom_range(0, 2) == 0) begin
                lu_pend = 1'b1;
                l_rd = 5'($urandom_range(0, 31));
                l_d = DW'($urandom);
            end
            if (!s_stall) begin
                pipe_valid = ($urandom_range(0, 9) < 7);
                p_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_d = DW'($urandom);
            end
            drive(pipe_valid, p_rd, p_d, lu_pend, l_rd, l_d,
                  ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step();
            if (m_acc) lu_pend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
